// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with true-LRU age counters, invalidation and one-cycle flush.
// Optional statistics counters are compiled in when BTB_STATS_EN is defined.
module btb_assoc #(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 4,
  parameter int NUM_LANES = 2,
  parameter int TAG_BITS  = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_LANES-1:0]        fetch_valid,
  input  logic [NUM_LANES-1:0][31:0]  PCs,
  output logic [NUM_LANES-1:0]        btb_hits,
  output logic [NUM_LANES-1:0][31:0]  target_PCs,
  input  logic                        resolving_valid,
  input  logic                        resolving_taken,
  input  logic [31:0]                 resolving_branch_PC,
  input  logic [31:0]                 resolving_target_PC,
`ifdef BTB_STATS_EN
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_misses,
  output logic [31:0]                 stat_allocs,
  output logic [31:0]                 stat_evicts,
`endif
  input  logic                        flush
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]                valid_q, valid_n;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_BITS-1:0]  tag_q, tag_n;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][29:0]          tgt_q, tgt_n;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_BITS-1:0]  age_q, age_n;

  logic [IDX_BITS-1:0] r_idx;
  logic [TAG_BITS-1:0] r_tag;
  logic [NUM_WAYS-1:0] r_match;
  logic                r_hit, found_inv;
  logic [WAY_BITS-1:0] hit_way, inv_way, lru_way, sel_way, old_age;

  assign r_idx = resolving_branch_PC[2 +: IDX_BITS];
  assign r_tag = resolving_branch_PC[2+IDX_BITS +: TAG_BITS];

  // Way selection for the resolving branch, evaluated on committed state.
  always_comb begin
    r_match   = '0;
    r_hit     = 1'b0;
    found_inv = 1'b0;
    hit_way   = '0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      r_match[w] = valid_q[r_idx][w] && (tag_q[r_idx][w] == r_tag);
      if (r_match[w] && !r_hit) begin
        r_hit   = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[r_idx][w] && !found_inv) begin
        found_inv = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
      if (age_q[r_idx][w] == '0)
        lru_way = WAY_BITS'(w);
    end
    if (r_hit)
      sel_way = hit_way;
    else if (found_inv)
      sel_way = inv_way;
    else
      sel_way = lru_way;
    old_age = age_q[r_idx][sel_way];
  end

  // Next-state: reset beats flush, flush drops any same-cycle resolve.
  always_comb begin
    valid_n = valid_q;
    tag_n   = tag_q;
    tgt_n   = tgt_q;
    age_n   = age_q;
    if (reset) begin
      valid_n = '0;
      tag_n   = '0;
      tgt_n   = '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_n[s][w] = WAY_BITS'(w);
    end else if (flush) begin
      valid_n = '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_n[s][w] = WAY_BITS'(w);
    end else if (resolving_valid) begin
      if (resolving_taken) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == sel_way) begin
            valid_n[r_idx][w] = 1'b1;
            tag_n[r_idx][w]   = r_tag;
            tgt_n[r_idx][w]   = resolving_target_PC[31:2];
            age_n[r_idx][w]   = WAY_BITS'(NUM_WAYS-1);
          end else if (age_q[r_idx][w] > old_age) begin
            age_n[r_idx][w] = age_q[r_idx][w] - WAY_BITS'(1);
          end
        end
      end else if (r_hit) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == hit_way) begin
            valid_n[r_idx][w] = 1'b0;
            age_n[r_idx][w]   = '0;
          end else if (age_q[r_idx][w] < old_age) begin
            age_n[r_idx][w] = age_q[r_idx][w] + WAY_BITS'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    valid_q <= valid_n;
    tag_q   <= tag_n;
    tgt_q   <= tgt_n;
    age_q   <= age_n;
  end

  // Lookups see next state so a same-cycle resolve or flush is visible immediately.
  logic [IDX_BITS-1:0] l_idx;
  logic [TAG_BITS-1:0] l_tag;

  always_comb begin
    btb_hits   = '0;
    target_PCs = '0;
    l_idx      = '0;
    l_tag      = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      l_idx = PCs[l][2 +: IDX_BITS];
      l_tag = PCs[l][2+IDX_BITS +: TAG_BITS];
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (valid_n[l_idx][w] && (tag_n[l_idx][w] == l_tag)) begin
          btb_hits[l]   = 1'b1;
          target_PCs[l] = {tgt_n[l_idx][w], 2'b00};
        end
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCs, resolving_branch_PC, resolving_target_PC[1:0], r_match};

`ifdef BTB_STATS_EN
  localparam int CNT_BITS = $clog2(NUM_LANES+1);

  logic [CNT_BITS-1:0] lane_hits, lane_misses;
  logic                alloc_ev, evict_ev;

  always_comb begin
    lane_hits   = '0;
    lane_misses = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (fetch_valid[l]) begin
        if (btb_hits[l])
          lane_hits = lane_hits + CNT_BITS'(1);
        else
          lane_misses = lane_misses + CNT_BITS'(1);
      end
    end
  end

  assign alloc_ev = !flush && resolving_valid && resolving_taken && !r_hit;
  assign evict_ev = alloc_ev && !found_inv;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_allocs <= '0;
      stat_evicts <= '0;
    end else begin
      stat_hits   <= sat_add(stat_hits, 32'(lane_hits));
      stat_misses <= sat_add(stat_misses, 32'(lane_misses));
      stat_allocs <= sat_add(stat_allocs, {31'b0, alloc_ev});
      stat_evicts <= sat_add(stat_evicts, {31'b0, evict_ev});
    end
  end
`else
  logic unused_fetch_valid;
  assign unused_fetch_valid = ^fetch_valid;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Randomized self-checking bench for btb_assoc against a recency-list reference model.
module tb_btb_assoc;
  localparam int NS = 16, NW = 4, NL = 2, TB = 10, IB = 4;

  logic clock = 1'b0;
  logic reset, flush, resolving_valid, resolving_taken;
  logic [NL-1:0] fetch_valid, btb_hits;
  logic [NL-1:0][31:0] PCs, target_PCs;
  logic [31:0] resolving_branch_PC, resolving_target_PC;
`ifdef BTB_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_allocs, stat_evicts;
`endif

  always #5 clock = ~clock;

  btb_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW), .NUM_LANES(NL), .TAG_BITS(TB)) dut (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .PCs(PCs),
    .btb_hits(btb_hits), .target_PCs(target_PCs),
    .resolving_valid(resolving_valid), .resolving_taken(resolving_taken),
    .resolving_branch_PC(resolving_branch_PC), .resolving_target_PC(resolving_target_PC),
`ifdef BTB_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_allocs(stat_allocs), .stat_evicts(stat_evicts),
`endif
    .flush(flush));

  int n_cmp = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: per-set entries plus a recency list, ord[s][0] = LRU.
  bit          m_valid[NS][NW];
  int unsigned m_tag[NS][NW];
  logic [31:0] m_tgt[NS][NW];
  int          ord[NS][NW];
  int unsigned e_hits, e_misses, e_allocs, e_evicts;
  bit          stats_known = 1'b0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % NS;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * NS)) % (1 << TB);
  endfunction

  task automatic reset_order();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < NW; i++) ord[s][i] = i;
  endtask

  task automatic promote(input int s, input int w, input bit to_mru);
    int tmp[$];
    for (int i = 0; i < NW; i++)
      if (ord[s][i] != w) tmp.push_back(ord[s][i]);
    if (to_mru) tmp.push_back(w);
    else tmp.push_front(w);
    for (int i = 0; i < NW; i++) ord[s][i] = tmp[i];
  endtask

  function automatic int find_match(input logic [31:0] pc);
    int unsigned s = idx_of(pc);
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
    return -1;
  endfunction

  task automatic model_apply(input bit rst, input bit fl, input bit rv, input bit rt,
                             input logic [31:0] rpc, input logic [31:0] rtgt);
    int unsigned s;
    int m, w;
    if (rst) begin
      for (int a = 0; a < NS; a++)
        for (int b = 0; b < NW; b++) m_valid[a][b] = 1'b0;
      reset_order();
      e_hits = 0; e_misses = 0; e_allocs = 0; e_evicts = 0;
    end else if (fl) begin
      for (int a = 0; a < NS; a++)
        for (int b = 0; b < NW; b++) m_valid[a][b] = 1'b0;
      reset_order();
    end else if (rv) begin
      s = idx_of(rpc);
      m = find_match(rpc);
      if (rt) begin
        w = m;
        if (w < 0)
          for (int b = NW - 1; b >= 0; b--) if (!m_valid[s][b]) w = b;
        if (w < 0) w = ord[s][0];
        if (m < 0) begin
          e_allocs++;
          if (m_valid[s][w]) e_evicts++;
        end
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = tag_of(rpc);
        m_tgt[s][w]   = rtgt & 32'hFFFF_FFFC;
        promote(s, w, 1'b1);
      end else if (m >= 0) begin
        m_valid[s][m] = 1'b0;
        promote(s, m, 1'b0);
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit fl, input bit rv, input bit rt,
                       input logic [31:0] rpc, input logic [31:0] rtgt,
                       input logic [NL-1:0] fv, input logic [31:0] p0, input logic [31:0] p1);
    int m;
    logic [31:0] lane_pc;
    @(negedge clock);
`ifdef BTB_STATS_EN
    if (stats_known) begin
      check_val("stat_hits", stat_hits, e_hits);
      check_val("stat_misses", stat_misses, e_misses);
      check_val("stat_allocs", stat_allocs, e_allocs);
      check_val("stat_evicts", stat_evicts, e_evicts);
    end
`endif
    reset = rst; flush = fl; resolving_valid = rv; resolving_taken = rt;
    resolving_branch_PC = rpc; resolving_target_PC = rtgt;
    fetch_valid = fv; PCs[0] = p0; PCs[1] = p1;
    model_apply(rst, fl, rv, rt, rpc, rtgt);
    #1;
    for (int l = 0; l < NL; l++) begin
      lane_pc = (l == 0) ? p0 : p1;
      m = find_match(lane_pc);
      check_val("lane_hit", btb_hits[l], (m >= 0) ? 32'd1 : 32'd0);
      check_val("lane_target", target_PCs[l], (m >= 0) ? m_tgt[idx_of(lane_pc)][m] : 32'd0);
      if (!rst && fv[l]) begin
        if (m >= 0) e_hits++;
        else e_misses++;
      end
    end
    if (rst) stats_known = 1'b1;
  endtask

  task automatic idle_lookup(input logic [31:0] p0, input logic [31:0] p1);
    cycle(0, 0, 0, 0, 0, 0, 2'b11, p0, p1);
  endtask

  task automatic taken(input logic [31:0] pc, input logic [31:0] tgt);
    cycle(0, 0, 1, 1, pc, tgt, 2'b11, pc, 32'h0);
  endtask

  task automatic fill();
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    taken(32'h1000, 32'h2000);
    taken(32'h1040, 32'h2040);
    taken(32'h1080, 32'h2080);
    taken(32'h10C0, 32'h20C0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom;
    p[2 +: IB] = 4'($urandom_range(0, 1));
    p[2+IB +: TB] = 10'($urandom_range(0, 5));
    return p;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; resolving_valid = 1'b0; resolving_taken = 1'b0;
    resolving_branch_PC = '0; resolving_target_PC = '0; fetch_valid = '0; PCs = '0;

    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    idle_lookup(32'h1000, 32'h1040);
    check_val("reset_hit", btb_hits[0], 0);
    check_val("reset_tgt", target_PCs[0], 0);
    taken(32'h1000, 32'h2000);
    check_val("same_cycle_hit", btb_hits[0], 1);
    check_val("same_cycle_tgt", target_PCs[0], 32'h2000);
    idle_lookup(32'h1000, 32'h0);
    check_val("next_cycle_tgt", target_PCs[0], 32'h2000);

    fill();
    taken(32'h1100, 32'h2100);
    idle_lookup(32'h1000, 32'h1100);
    check_val("evict_lru", btb_hits[0], 0);
    check_val("new_entry", btb_hits[1], 1);
    idle_lookup(32'h1040, 32'h10C0);
`ifdef BTB_STATS_EN
    check_val("plan_allocs", stat_allocs, 5);
    check_val("plan_evicts", stat_evicts, 1);
`endif

    fill();
    taken(32'h1000, 32'h3000);
    taken(32'h1100, 32'h2100);
    idle_lookup(32'h1040, 32'h1000);
    check_val("refresh_evict", btb_hits[0], 0);
    check_val("refresh_tgt", target_PCs[1], 32'h3000);

    fill();
    cycle(0, 0, 1, 0, 32'h1080, 0, 2'b11, 32'h1080, 32'h1000);
    check_val("invalidate", btb_hits[0], 0);
    taken(32'h1140, 32'h4000);
    idle_lookup(32'h1140, 32'h10C0);
    check_val("reuse_invalid", target_PCs[0], 32'h4000);
    check_val("survivor", btb_hits[1], 1);

    fill();
    cycle(0, 1, 1, 1, 32'h1200, 32'h5000, 2'b11, 32'h1000, 32'h1200);
    check_val("flush_hit0", btb_hits[0], 0);
    check_val("flush_drop", btb_hits[1], 0);
    idle_lookup(32'h10C0, 32'h1200);
    check_val("after_flush", btb_hits, 0);

    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    taken(32'h1000, 32'h2000);
    idle_lookup(32'h11000, 32'h0);
    check_val("alias_hit", btb_hits[0], 1);
    check_val("alias_tgt", target_PCs[0], 32'h2000);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 200) == 0, ($urandom % 60) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, rand_pc(), $urandom,
            2'($urandom_range(0, 3)), rand_pc(), rand_pc());
    end
    idle_lookup(rand_pc(), rand_pc());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage. It serves `NUM_LANES` same-cycle lookups. Each resolving branch from the branch stack either allocates/refreshes its entry (taken) or invalidates it (not taken). Replacement is true LRU, kept with per-way age counters. It supersedes the fixed-geometry BTB and adds three things: invalidation, a one-cycle global flush, and optional statistics counters.

## Interface
- `NUM_SETS`, 16, number of sets; power of 2, ≥2; `IDX_BITS = $clog2(NUM_SETS)`.
- `NUM_WAYS`, 4, ways per set; power of 2, ≥2.
- `NUM_LANES`, 2, parallel lookup lanes.
- `TAG_BITS`, 10, partial tag width; `2+IDX_BITS+TAG_BITS ≤ 32`.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `fetch_valid`  in  `NUM_LANES`  lane lookup qualifier (statistics only).
- `PCs`  in  `NUM_LANES`×32  lookup PCs.
- `btb_hits`  out  `NUM_LANES`  lane hit.
- `target_PCs`  out  `NUM_LANES`×32  predicted target; 0 on miss.
- `resolving_valid`  in  1  resolving-branch strobe.
- `resolving_taken`  in  1  1 = allocate/refresh; 0 = invalidate.
- `resolving_branch_PC`  in  32  PC of the resolving branch.
- `resolving_target_PC`  in  32  its target.
- `flush`  in  1  invalidate the whole BTB.
- `stat_hits`, `stat_misses`, `stat_allocs`, `stat_evicts`  out  32 each  present only with `BTB_STATS_EN`.

## Operation
- Index is `PC[2 +: IDX_BITS]`. Tag is `PC[2+IDX_BITS +: TAG_BITS]`. PCs sharing index and partial tag alias; this is intended.
- Each entry holds `valid`, `tag`, `target[31:2]`. Targets are output as `{target,2'b00}`.
- Each way holds an age `0..NUM_WAYS-1`; `NUM_WAYS-1` is MRU. Within a set the ages are always a permutation. Reset and flush set age = way index.
- Lookup hits when an entry is valid and its tag matches. A set never holds two valid entries with the same tag. Lookups never change LRU state.
- Taken update:
  - Way select: matching valid way if present, else lowest-index invalid way, else the age-0 way (eviction).
  - Write `tag`, `target`, `valid=1`; set age to MRU.
  - Every way whose age is greater than the selected way's old age decrements by 1.
- Not-taken update:
  - On a match: clear `valid`, set age to 0, and increment every way whose age is less than the old age.
  - On a miss: no change.
- `flush` takes priority over a same-cycle resolve; the resolve is dropped.
- Lookups read next state. A resolve or flush in cycle t is visible to lookups in cycle t. This includes a lookup in the set or on the PC being updated.

## Timing
- Lookup is purely combinational: zero latency.
- State updates on the posedge after the request. One resolve is accepted per cycle, with no backpressure.
- Reset clears all entries, so `btb_hits` = 0 and `target_PCs` = 0 for any PC. Statistics read 0.
- Reset wins over flush and resolve. Reset asserted mid-stream discards the in-flight request.
- Eviction occurs only when all ways of the set are valid and none matches.

## Configuration
- `BTB_STATS_EN` defined: four 32-bit saturating counters, each reset to 0 and not cleared by flush.
  - `stat_hits` / `stat_misses`: add the number of lanes with `fetch_valid` that hit / miss this cycle. Up to `NUM_LANES` per cycle.
  - `stat_allocs`: +1 per taken resolve that writes a non-matching way.
  - `stat_evicts`: +1 when that write replaces a valid entry.
- `BTB_STATS_EN` undefined: stat ports and counters are absent; all other behaviour is identical.

## Test plan
Defaults apply; PC `0x1000` maps to set 0, tag `0x040`.
- Reset, then look up `0x1000` → hit 0, target 0. Resolve taken `0x1000`→`0x2000` with a same-cycle lookup → hit 1, target `0x2000` that cycle and the next.
- Resolve taken `0x1000`, `0x1040`, `0x1080`, `0x10C0` (all set 0), then `0x1100`.
  - Result: `0x1000` misses; the other four hit.
  - With stats: allocs = 5, evicts = 1.
- Fill as above, then re-resolve `0x1000`→`0x3000`, then insert `0x1100`. Result: `0x1040` is evicted; `0x1000` hits with `0x3000`.
- Fill, then resolve not-taken `0x1080`, then taken `0x1140`→`0x4000`.
  - Result: `0x1080` misses; `0x1140` hits; the other three still hit.
  - Evicts is unchanged.
- Fill, then assert `flush` with a concurrent taken resolve of `0x1200`. Result: every lookup misses that cycle and after; `0x1200` is not written.
- Insert `0x1000`→`0x2000`, then look up `0x11000` (same index and tag) → hit, target `0x2000`: alias confirmed.
